// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// default latencies and FSM state type.
package muldiv_ctrl_pkg;

  localparam int unsigned MULT_CYCLES_DFLT = 5;
  localparam int unsigned DIV_CYCLES_DFLT  = 10;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_arith.sv
// Combinational multiply/divide datapath producing HI/LO results for one op.
module md_arith
  import muldiv_ctrl_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  MUL_SEL,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  logic        sgn;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag;
  logic [63:0] a_ext, b_ext, prod;

  always_comb begin
    sgn         = md_is_signed(MUL_SEL);
    div_by_zero = md_is_div(MUL_SEL) && (B == '0);

    // Low 64 bits of the product of the extended operands equal the true
    // signed or unsigned 64-bit product.
    a_ext = {{32{sgn & A[31]}}, A};
    b_ext = {{32{sgn & B[31]}}, B};
    prod  = a_ext * b_ext;

    // Magnitude division; INT_MIN has magnitude 0x80000000 as unsigned, so
    // INT_MIN / -1 naturally yields 0x80000000 with zero remainder.
    a_neg  = sgn & A[31];
    b_neg  = sgn & B[31];
    a_mag  = a_neg ? (~A + 32'd1) : A;
    b_mag  = b_neg ? (~B + 32'd1) : B;
    b_safe = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;

    hi = '0;
    lo = '0;
    if (div_by_zero) begin
      hi = '0;
      lo = '0;
    end else if (md_is_div(MUL_SEL)) begin
      lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      hi = a_neg ? (~r_mag + 32'd1) : r_mag;
    end else begin
      hi = prod[63:32];
      lo = prod[31:0];
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// E-stage multiply/divide sequencer: fixed-latency busy window, pending
// result registers, HI/LO commit, mthi/mtlo writes and mfhi/mflo read port.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DFLT,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  MUL_SEL,
  input  logic        w,
  input  logic        W_SEL,
  input  logic        HL_SEL,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] RD
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               dz_q;
  logic [31:0]        hi_q, lo_q;
  logic [31:0]        p_hi_q, p_lo_q;

  logic [31:0]        ar_hi, ar_lo;
  logic               ar_dz;

  md_arith u_arith (
    .A           (A),
    .B           (B),
    .MUL_SEL     (MUL_SEL),
    .hi          (ar_hi),
    .lo          (ar_lo),
    .div_by_zero (ar_dz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            p_hi_q  <= ar_hi;
            p_lo_q  <= ar_lo;
            dz_q    <= ar_dz;
            cnt_q   <= md_is_div(MUL_SEL) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else if (w) begin
            if (W_SEL) hi_q <= A;
            else       lo_q <= A;
          end
        end
        S_RUN: begin
          // start/w are deliberately not looked at here.
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (!dz_q) begin
              hi_q <= p_hi_q;
              lo_q <= p_lo_q;
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign RD   = HL_SEL ? hi_q : lo_q;

endmodule
